// File: rtl/src2_operand_decoder_if.sv
// Operand-decode bus: instruction intake, register-file read port and the
// operand bundle handed to the src2 shifter/ALU.
interface src2_operand_decoder_if #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 4
);
    logic             flush;
    logic [31:0]      instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [RA_W-1:0]  rf_addr;
    logic [WIDTH-1:0] rf_data;
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_state;
    logic [23:0]      imm24;
    logic [WIDTH-1:0] rm_val;
    logic [WIDTH-1:0] rs_val;
    logic [RA_W-1:0]  rd_addr;
    logic [RA_W-1:0]  rn_addr;
    logic             rrx;
    logic             illegal;

    // Decoder side
    modport master (
        input  flush, instr, instr_valid, rf_data, op_ready,
        output instr_ready, rf_addr, op_valid, op_state, imm24,
               rm_val, rs_val, rd_addr, rn_addr, rrx, illegal
    );

    // Environment side: instruction source, register file and shifter
    modport slave (
        output flush, instr, instr_valid, rf_data, op_ready,
        input  instr_ready, rf_addr, op_valid, op_state, imm24,
               rm_val, rs_val, rd_addr, rn_addr, rrx, illegal
    );
endinterface

// File: rtl/src2_operand_decoder.sv
// src2 operand decoder: classifies ARM instructions into shifter operand modes
// and fetches Rs/Rm over one read port. Define SRC2_DEC_OVERLAP_EN to accept a
// new instruction in the same cycle the current bundle retires.
module src2_operand_decoder #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    src2_operand_decoder_if.master bus
);

    localparam logic [3:0] ROT_IMM8  = 4'd0;
    localparam logic [3:0] SHAMT_LSL = 4'd1;
    localparam logic [3:0] RS_LSL    = 4'd5;
    localparam logic [3:0] IMM12     = 4'd9;
    localparam logic [3:0] BRANCH    = 4'd10;
    localparam logic [3:0] DIR_RM    = 4'd11;

    typedef enum logic [1:0] {IDLE, RS_RD, RM_RD, ISSUE} state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       rrx;
        logic       illegal;
    } dec_t;

    state_t state, state_nxt;

    logic [23:0]      ins_q;
    logic [3:0]       op_state_q;
    logic             rrx_q;
    logic             illegal_q;
    logic [WIDTH-1:0] rm_q;
    logic [WIDTH-1:0] rs_q;

    logic accept;
    dec_t dec;

    // Immediate shift: #0 with LSL is a plain Rm, with ROR it is RRX
    function automatic logic [3:0] shamt_code(input logic [1:0] sh, input logic [4:0] shamt);
        if (shamt == 5'd0 && (sh == 2'b00 || sh == 2'b11))
            return DIR_RM;
        return SHAMT_LSL + {2'b00, sh};
    endfunction

    function automatic dec_t classify(input logic [31:0] ins);
        dec_t       d;
        logic [1:0] op;
        logic       imm;
        logic       shift_imm;
        op        = ins[27:26];
        imm       = ins[25];
        shift_imm = ((op == 2'b00) && !imm && !ins[4]) || ((op == 2'b01) && imm);
        d.code    = ROT_IMM8;
        d.illegal = 1'b0;
        d.rrx     = shift_imm && (ins[11:7] == 5'd0) && (ins[6:5] == 2'b11);
        case (op)
            2'b00: begin
                if (imm)
                    d.code = ROT_IMM8;
                else if (ins[4])
                    d.code = RS_LSL + {2'b00, ins[6:5]};
                else
                    d.code = shamt_code(ins[6:5], ins[11:7]);
            end
            2'b01:   d.code = imm ? shamt_code(ins[6:5], ins[11:7]) : IMM12;
            2'b10:   d.code = BRANCH;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    function automatic state_t route(input logic [3:0] code);
        if (code == ROT_IMM8 || code == IMM12 || code == BRANCH)
            return ISSUE;
        if (code >= RS_LSL && code <= RS_LSL + 4'd3)
            return RS_RD;
        return RM_RD;
    endfunction

    assign dec = classify(bus.instr);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.instr_ready = 1'b0;
        bus.rf_addr     = '0;
        bus.op_valid    = 1'b0;

`ifdef SRC2_DEC_OVERLAP_EN
        bus.instr_ready = ((state == IDLE) ||
                           (state == ISSUE && bus.op_ready && !bus.flush)) && !reset;
`else
        bus.instr_ready = (state == IDLE) && !reset;
`endif
        accept = bus.instr_valid && bus.instr_ready && !bus.flush;

        case (state)
            RS_RD:   bus.rf_addr = RA_W'(ins_q[11:8]);
            RM_RD:   bus.rf_addr = RA_W'(ins_q[3:0]);
            ISSUE:   bus.op_valid = 1'b1;
            default: ;
        endcase

        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (accept && !dec.illegal) state_nxt = route(dec.code);
                RS_RD: state_nxt = RM_RD;
                RM_RD: state_nxt = ISSUE;
                ISSUE: begin
                    if (bus.op_ready)
                        state_nxt = (accept && !dec.illegal) ? route(dec.code) : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bundle registers: captured on accept, operands filled in by the read states
    always_ff @(posedge clk) begin
        if (reset) begin
            ins_q      <= '0;
            op_state_q <= '0;
            rrx_q      <= 1'b0;
            illegal_q  <= 1'b0;
            rm_q       <= '0;
            rs_q       <= '0;
        end else begin
            illegal_q <= accept && dec.illegal;
            if (accept && !dec.illegal) begin
                ins_q      <= bus.instr[23:0];
                op_state_q <= dec.code;
                rrx_q      <= dec.rrx;
                rm_q       <= '0;
                rs_q       <= '0;
            end else if (state == RS_RD && !bus.flush) begin
                rs_q <= {{(WIDTH-8){1'b0}}, bus.rf_data[7:0]};
            end else if (state == RM_RD && !bus.flush) begin
                rm_q <= bus.rf_data;
            end
        end
    end

    assign bus.op_state = op_state_q;
    assign bus.imm24    = ins_q;
    assign bus.rd_addr  = RA_W'(ins_q[15:12]);
    assign bus.rn_addr  = RA_W'(ins_q[19:16]);
    assign bus.rm_val   = rm_q;
    assign bus.rs_val   = rs_q;
    assign bus.rrx      = rrx_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_src2_operand_decoder.sv
// Scoreboard bench for src2_operand_decoder: expected bundles are queued when
// an instruction is driven and popped when the decoder hands a bundle over.
module tb_src2_operand_decoder;

    typedef struct packed {
        logic [3:0]  op_state;
        logic [23:0] imm24;
        logic [31:0] rm;
        logic [31:0] rs;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic        rrx;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] rf [16];

    exp_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_ret    = 0;

`ifdef SRC2_DEC_OVERLAP_EN
    localparam logic OVERLAP = 1'b1;
`else
    localparam logic OVERLAP = 1'b0;
`endif

    src2_operand_decoder_if #(.WIDTH(32), .RA_W(4)) bus ();

    src2_operand_decoder #(.WIDTH(32), .RA_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb bus.rf_data = rf[bus.rf_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic [31:0] ins,
                                input logic [31:0] rm, input logic [31:0] rs,
                                input logic [3:0] rd, input logic [3:0] rn, input logic rrx);
        exp_t e;
        e.op_state = st;
        e.imm24    = ins[23:0];
        e.rm       = rm;
        e.rs       = rs;
        e.rd       = rd;
        e.rn       = rn;
        e.rrx      = rrx;
        return e;
    endfunction

    // Monitor: every valid handshake outside a flush cycle retires one bundle
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.op_valid && bus.op_ready && !bus.flush) begin
            n_ret++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_bundle", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("op_state", {28'd0, bus.op_state}, {28'd0, e.op_state});
                chk("imm24",    {8'd0, bus.imm24},    {8'd0, e.imm24});
                chk("rm_val",   bus.rm_val,           e.rm);
                chk("rs_val",   bus.rs_val,           e.rs);
                chk("rd_addr",  {28'd0, bus.rd_addr}, {28'd0, e.rd});
                chk("rn_addr",  {28'd0, bus.rn_addr}, {28'd0, e.rn});
                chk("rrx",      {31'd0, bus.rrx},     {31'd0, e.rrx});
            end
        end
    end

    task automatic run_one(input logic [31:0] ins, input exp_t e, input int lat,
                           input logic [3:0] ra0, input logic [3:0] ra1, input int hold);
        int n;
        @(posedge clk); #1;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        chk("instr_ready_idle", {31'd0, bus.instr_ready}, 32'd1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.op_valid) begin
                n = k;
                break;
            end
            if (k == 1) chk("rf_addr_first",  {28'd0, bus.rf_addr}, {28'd0, ra0});
            if (k == 2) chk("rf_addr_second", {28'd0, bus.rf_addr}, {28'd0, ra1});
        end
        chk("latency", n, lat);
        if (n == 0) begin
            sb.delete();
            return;
        end
        chk("rf_addr_issue", {28'd0, bus.rf_addr}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_op_valid", {31'd0, bus.op_valid}, 32'd1);
            chk("hold_op_state", {28'd0, bus.op_state}, {28'd0, e.op_state});
            chk("hold_rm_val",   bus.rm_val, e.rm);
            chk("hold_rs_val",   bus.rs_val, e.rs);
        end
        @(posedge clk); #1;
        bus.op_ready = 1'b1;
        @(negedge clk);
        chk("instr_ready_retire", {31'd0, bus.instr_ready}, {31'd0, OVERLAP});
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
        @(negedge clk);
        chk("op_valid_after_retire", {31'd0, bus.op_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int base;
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        rf[1]  = 32'h1234_5678;
        rf[2]  = 32'hAAAA_0000;
        rf[3]  = 32'h0000_0F05;
        rf[10] = 32'hFFFF_FF80;
        bus.flush       = 1'b0;
        bus.instr       = 32'd0;
        bus.instr_valid = 1'b0;
        bus.op_ready    = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_instr_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk("reset_op_valid",    {31'd0, bus.op_valid},    32'd0);
        chk("reset_op_state",    {28'd0, bus.op_state},    32'd0);
        chk("reset_imm24",       {8'd0, bus.imm24},        32'd0);
        chk("reset_rm_val",      bus.rm_val,               32'd0);
        chk("reset_rs_val",      bus.rs_val,               32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_instr_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("idle_rf_addr",     {28'd0, bus.rf_addr},     32'd0);
        chk("idle_illegal",     {31'd0, bus.illegal},     32'd0);

        run_one(32'hE28214FF, mk(4'd0,  32'hE28214FF, 32'd0,        32'd0,  4'd1, 4'd2, 1'b0), 1, 4'd0, 4'd0, 0);
        run_one(32'hE1A00181, mk(4'd1,  32'hE1A00181, 32'h12345678, 32'd0,  4'd0, 4'd0, 1'b0), 2, 4'd1, 4'd0, 0);
        run_one(32'hE0810332, mk(4'd6,  32'hE0810332, 32'hAAAA0000, 32'h05, 4'd0, 4'd1, 1'b0), 3, 4'd3, 4'd2, 3);
        run_one(32'hE1A00061, mk(4'd11, 32'hE1A00061, 32'h12345678, 32'd0,  4'd0, 4'd0, 1'b1), 2, 4'd1, 4'd0, 0);
        run_one(32'hE5910004, mk(4'd9,  32'hE5910004, 32'd0,        32'd0,  4'd0, 4'd1, 1'b0), 1, 4'd0, 4'd0, 0);
        run_one(32'hEA000010, mk(4'd10, 32'hEA000010, 32'd0,        32'd0,  4'd0, 4'd0, 1'b0), 1, 4'd0, 4'd0, 0);
        run_one(32'hE1A00A51, mk(4'd7,  32'hE1A00A51, 32'h12345678, 32'h80, 4'd0, 4'd0, 1'b0), 3, 4'd10, 4'd1, 0);
        run_one(32'hE7910021, mk(4'd2,  32'hE7910021, 32'h12345678, 32'd0,  4'd0, 4'd1, 1'b0), 2, 4'd1, 4'd0, 0);
        run_one(32'hE1A00161, mk(4'd4,  32'hE1A00161, 32'h12345678, 32'd0,  4'd0, 4'd0, 1'b0), 2, 4'd1, 4'd0, 1);

        // Undefined op field: one-cycle illegal pulse, no bundle
        @(posedge clk); #1;
        bus.instr       = 32'hEC000000;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("illegal_pulse",       {31'd0, bus.illegal},     32'd1);
        chk("illegal_op_valid",    {31'd0, bus.op_valid},    32'd0);
        chk("illegal_instr_ready", {31'd0, bus.instr_ready}, 32'd1);
        @(negedge clk);
        chk("illegal_one_cycle",   {31'd0, bus.illegal},     32'd0);
        chk("illegal_no_bundle",   {31'd0, bus.op_valid},    32'd0);

        // Flush while the bundle waits in ISSUE; the handshake and new instr are void
        @(posedge clk); #1;
        bus.instr       = 32'hE28214FF;
        bus.instr_valid = 1'b1;
        sb.push_back(mk(4'd0, 32'hE28214FF, 32'd0, 32'd0, 4'd1, 4'd2, 1'b0));
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("flush_pre_valid", {31'd0, bus.op_valid}, 32'd1);
        @(posedge clk); #1;
        bus.flush       = 1'b1;
        bus.op_ready    = 1'b1;
        bus.instr       = 32'hEA000010;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        chk("flush_instr_ready", {31'd0, bus.instr_ready}, 32'd0);
        @(posedge clk); #1;
        bus.flush       = 1'b0;
        bus.op_ready    = 1'b0;
        bus.instr_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_op_valid",    {31'd0, bus.op_valid},    32'd0);
        chk("flush_instr_ready_after", {31'd0, bus.instr_ready}, 32'd1);
        @(negedge clk);
        chk("flush_no_accept",   {31'd0, bus.op_valid},    32'd0);

        // Flush during the Rs read aborts the fetch
        @(posedge clk); #1;
        bus.instr       = 32'hE0810332;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.flush       = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush_rs_no_valid", {31'd0, bus.op_valid}, 32'd0);
        end

`ifdef SRC2_DEC_OVERLAP_EN
        // Back-to-back immediates retire on consecutive cycles
        base = n_ret;
        @(posedge clk); #1;
        bus.op_ready    = 1'b1;
        bus.instr       = 32'hE28214FF;
        bus.instr_valid = 1'b1;
        sb.push_back(mk(4'd0, 32'hE28214FF, 32'd0, 32'd0, 4'd1, 4'd2, 1'b0));
        @(posedge clk); #1;
        bus.instr = 32'hE5910004;
        sb.push_back(mk(4'd9, 32'hE5910004, 32'd0, 32'd0, 4'd0, 4'd1, 1'b0));
        @(negedge clk);
        chk("overlap_ready", {31'd0, bus.instr_ready}, 32'd1);
        @(posedge clk); #1;
        bus.instr = 32'hEA000010;
        sb.push_back(mk(4'd10, 32'hEA000010, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0));
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
        chk("overlap_retired", n_ret - base, 32'd3);
        @(negedge clk);
        chk("overlap_drained", {31'd0, bus.op_valid}, 32'd0);
`else
        base = n_ret;
        chk("retire_count", base, 32'd9);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/src2_operand_decoder.md
Name: src2_operand_decoder

Overview:
- Sequential decode stage that sits between the instruction register and the src2 shifter/ALU datapath.
- Classifies each 32-bit ARM instruction into the shifter's 4-bit operand-mode code and fetches Rs/Rm over a single register-file read port.
- Presents a stable operand bundle to the shifter with a valid/ready handshake.
- Acts as the initiator that drives the shifter's opState, Imm24, Rm and Rs inputs.

Parameters:
- WIDTH, 32, datapath width of register values.
- RA_W, 4, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort; drops the instruction in flight
- instr  in  32  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  decoder can accept an instruction
- rf_addr  out  RA_W  register-file read-port address
- rf_data  in  WIDTH  combinational read data for rf_addr
- op_valid  out  1  operand bundle valid
- op_ready  in  1  shifter/ALU consumes the bundle
- op_state  out  4  operand-mode code
- imm24  out  24  instr[23:0]
- rm_val  out  WIDTH  latched Rm value
- rs_val  out  WIDTH  {24'b0, Rs[7:0]}
- rd_addr  out  RA_W  instr[15:12]
- rn_addr  out  RA_W  instr[19:16]
- rrx  out  1  ROR #0 (RRX) request, executed by the ALU
- illegal  out  1  one-cycle pulse on an undefined op field

Behaviour:
- op_state codes: rotImm8=0, shamt5LSL=1, shamt5LSR=2, shamt5ASR=3, shamt5ROR=4, RsLSL=5, RsLSR=6, RsASR=7, RsROR=8, Imm12=9, BranchImm24=10, dirRm=11. Codes 12-15 are never emitted.
- Classification: op = instr[27:26], I = instr[25], sh = instr[6:5], shamt = instr[11:7].
  - op=00, I=1 -> 0.
  - op=00, I=0, instr[4]=0 -> shamt5 code by sh.
  - op=00, I=0, instr[4]=1 -> Rs code by sh (5..8).
  - op=01, I=0 -> 9.
  - op=01, I=1 -> shamt5 code by sh.
  - op=10 -> 10.
  - op=11 -> illegal.
  - shamt=0 with sh=00 -> 11.
  - shamt=0 with sh=11 -> 11 with rrx=1.
  - shamt=0 with sh=01/10 remains code 2/3 (ARM #32 semantics are the shifter's concern).
- FSM states: IDLE, RS_RD, RM_RD, ISSUE.
  - instr_ready = (state==IDLE) & ~reset.
  - IDLE, handshake: latch instr.
    - Codes 0/9/10 -> ISSUE.
    - Codes 5-8 -> RS_RD.
    - Others -> RM_RD.
    - op=11: assert illegal for 1 cycle, stay in IDLE.
  - RS_RD: rf_addr = instr[11:8]; latch rs_val = {24'b0, rf_data[7:0]} -> RM_RD.
  - RM_RD: rf_addr = instr[3:0]; latch rm_val -> ISSUE.
  - ISSUE: op_valid=1; all bundle outputs held stable until op_valid & op_ready, then -> IDLE.
- Latency from accept edge to op_valid: 1 cycle (immediate/branch), 2 cycles (Rm only), 3 cycles (Rs).
- rf_addr = 0 in IDLE and ISSUE.
- For modes that do not use Rm/Rs, the unused rm_val/rs_val are 0.
- Reset: state IDLE; op_valid, illegal, rrx = 0; op_state=0, imm24=0, rm_val=0, rs_val=0, rd_addr=0, rn_addr=0.
- flush in any state -> IDLE next cycle.
  - op_valid deasserts next cycle; any handshake in the flush cycle is void.
  - An instr_valid presented in the flush cycle is not accepted.
- Reset has priority over flush.
- instr_valid is ignored when instr_ready=0.

Optional Feature:
- Macro: SRC2_DEC_OVERLAP_EN.
- Defined:
  - instr_ready = IDLE | (ISSUE & op_ready & ~flush).
  - A new instruction is accepted in the same cycle the current bundle retires.
  - Sustained immediate-mode throughput is 1 per cycle.
- Undefined: instr_ready only in IDLE; minimum one bubble between bundles.

Test Plan:
- ADD r1,r2,#0xFF ror 8, 0xE28214FF -> op_valid 1 cycle after accept; op_state=0, imm24=0x8214FF, rn_addr=2, rd_addr=1.
- MOV r0,r1,LSL #3, 0xE1A00181, rf[r1]=0x12345678 -> rf_addr=1 in RM_RD; op_state=1, rm_val=0x12345678, latency 2.
- ADD r0,r1,r2,LSR r3, 0xE0810332, rf[r3]=0x00000F05, rf[r2]=0xAAAA0000 -> rf_addr=3 then 2; op_state=6, rs_val=0x05, rm_val=0xAAAA0000, latency 3.
- MOV r0,r1,RRX, 0xE1A00061 -> op_state=11, rrx=1. LDR r0,[r1,#4], 0xE5910004 -> op_state=9. B, 0xEA000010 -> op_state=10, imm24=0x000010.
- 0xEC000000 -> illegal high exactly 1 cycle, op_valid never asserts, instr_ready stays 1.
- Bundle in ISSUE with op_ready=0 for 3 cycles -> outputs stable. Assert flush instead -> IDLE next cycle, op_valid=0. Overlap build: back-to-back immediates retire on consecutive cycles.
